// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: decode-side control, instruction memory port and the
// presented instruction/PC. The fetch stage is the master; decode and memory are the slave.
interface instruction_fetch_if;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halt;
    logic        addr_error;
    logic [31:0] fetch_count;

    modport master (
        input  stall, branch_taken, branch_offset, jump, jump_target, jr, jr_addr,
        input  imem_rdata,
        output imem_addr, instr, pc_out, pc_plus4, instr_valid, halt, addr_error,
        output fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_offset, jump, jump_target, jr, jr_addr,
        output imem_rdata,
        input  imem_addr, instr, pc_out, pc_plus4, instr_valid, halt, addr_error,
        input  fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC ownership, zero-bubble redirect, stall skid register
// and a BOOT/RUN/HALT controller that stops on bad fetch addresses.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic                       clk_CPU,
    input  logic                       rst_n,
    instruction_fetch_if.master        bus
);

    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_DEPTH) << 2;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] fetch_pc;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;
    logic        addr_error;
    logic [31:0] fetch_count;
    logic        hold_valid;
    logic [31:0] hold_reg;

    logic        redirect_en;
    logic [31:0] branch_target;
    logic [31:0] fetch_addr;
    logic        misaligned;
    logic        out_of_range;
    logic        halt_now;

    assign pc_plus4      = pc_out + 32'd4;
    assign branch_target = pc_plus4 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};

    // Redirect targets feed imem_addr directly so the target word arrives next cycle.
    always_comb begin
        redirect_en = (state == RUN) && instr_valid && !bus.stall;
        fetch_addr  = fetch_pc;
        if (redirect_en) begin
            if (bus.jr) begin
                fetch_addr = bus.jr_addr;
            end else if (bus.jump) begin
                fetch_addr = {pc_plus4[31:28], bus.jump_target, 2'b00};
            end else if (bus.branch_taken) begin
                fetch_addr = branch_target;
            end
        end
    end

    always_comb begin
        misaligned   = |fetch_addr[1:0];
        out_of_range = {1'b0, fetch_addr} >= IMEM_BYTES;
        halt_now     = (state == RUN) && !bus.stall && (misaligned || out_of_range);
        state_next   = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (halt_now) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk_CPU or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_CPU or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            addr_error  <= 1'b0;
            fetch_count <= '0;
            hold_valid  <= 1'b0;
            hold_reg    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    pc_out      <= RESET_PC;
                    fetch_pc    <= RESET_PC + 32'd4;
                    instr_valid <= 1'b1;
                end
                RUN: begin
                    if (!bus.stall) begin
                        pc_out      <= fetch_addr;
                        fetch_pc    <= fetch_addr + 32'd4;
                        hold_valid  <= 1'b0;
                        fetch_count <= fetch_count + 32'd1;
                        if (halt_now) begin
                            instr_valid <= 1'b0;
                            halted      <= 1'b1;
                            if (misaligned) addr_error <= 1'b1;
                        end
                    end else if (!hold_valid) begin
                        // Memory already moved on to fetch_pc; capture the word for pc_out.
                        hold_reg   <= bus.imem_rdata;
                        hold_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_addr   = fetch_addr;
    assign bus.instr       = hold_valid ? hold_reg : bus.imem_rdata;
    assign bus.pc_out      = pc_out;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.instr_valid = instr_valid;
    assign bus.halt        = halted;
    assign bus.addr_error  = addr_error;
    assign bus.fetch_count = fetch_count;

endmodule
